// File: rtl/pow_5_rr_arbiter.sv
// Round-robin arbiter that shares one multi-cycle pow_5 unit among N_REQ requesters.
// It serves one request at a time, waits for the unit's result or a timeout, and then returns the response.
module pow_5_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_n,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_vld,
  output logic [W-1:0]       rsp_res,
  output logic               rsp_err,
  output logic               busy,
  output logic               unit_n_vld,
  output logic [W-1:0]       unit_n,
  input  logic               unit_res_vld,
  input  logic [W-1:0]       unit_res
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ILAST = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [TW-1:0]    timer_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rsp_vld_q;
  logic [W-1:0]     rsp_res_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             unit_n_vld_q;
  logic [W-1:0]     unit_n_q;

  logic [IDW-1:0]   winner_d;
  logic [TW-1:0]    timer_d;

  // First asserted request at or after the pointer, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDW-1:0]   p);
    logic [IDW-1:0] w;
    int             idx;
    w = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % N_REQ;
      if (r[idx]) w = IDW'(idx);
    end
    return w;
  endfunction

  always_comb begin
    winner_d = rr_pick(req, ptr_q);
    timer_d  = timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      timer_q      <= '0;
      gnt_q        <= '0;
      rsp_vld_q    <= '0;
      rsp_res_q    <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      unit_n_vld_q <= 1'b0;
      unit_n_q     <= '0;
    end else begin
      // Grant is a single clk pulse, independent of clk_en.
      gnt_q <= '0;
      if (clk_en) begin
        case (state_q)
          IDLE: begin
            if (|req) begin
              id_q         <= winner_d;
              unit_n_q     <= req_n[int'(winner_d)*W +: W];
              gnt_q        <= N_REQ'(1) << winner_d;
              unit_n_vld_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= ISSUE;
            end
          end
          ISSUE: begin
            unit_n_vld_q <= 1'b0;
            timer_q      <= '0;
            state_q      <= WAIT;
          end
          WAIT: begin
            // A result arriving on the timeout cycle still counts as success.
            if (unit_res_vld) begin
              rsp_res_q <= unit_res;
              rsp_err_q <= 1'b0;
              rsp_vld_q <= N_REQ'(1) << id_q;
              state_q   <= RESP;
            end else if (timer_d == TLAST) begin
              rsp_res_q <= '0;
              rsp_err_q <= 1'b1;
              rsp_vld_q <= N_REQ'(1) << id_q;
              state_q   <= RESP;
            end else begin
              timer_q <= timer_d;
            end
          end
          RESP: begin
            rsp_vld_q <= '0;
            ptr_q     <= (id_q == ILAST) ? '0 : id_q + 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign gnt        = gnt_q;
  assign rsp_vld    = rsp_vld_q;
  assign rsp_res    = rsp_res_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign unit_n_vld = unit_n_vld_q;
  assign unit_n     = unit_n_q;

endmodule

// File: tb/tb_pow_5_rr_arbiter.sv
// Randomized bench for pow_5_rr_arbiter: a transaction-level round-robin model plus a pow_5 unit stub
// whose latency can be set (0 means the stub never answers).
module tb_pow_5_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           clk_en;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_n;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_vld;
  logic [W-1:0]   rsp_res;
  logic           rsp_err;
  logic           busy;
  logic           unit_n_vld;
  logic [W-1:0]   unit_n;
  logic           unit_res_vld;
  logic [W-1:0]   unit_res;

  pow_5_rr_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req(req), .req_n(req_n),
    .gnt(gnt), .rsp_vld(rsp_vld), .rsp_res(rsp_res), .rsp_err(rsp_err),
    .busy(busy), .unit_n_vld(unit_n_vld), .unit_n(unit_n),
    .unit_res_vld(unit_res_vld), .unit_res(unit_res)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   lat    = 5;
  int   en_mode = 0;
  int   en_edges = 0;
  int   ptr_m  = 0;
  logic stray  = 1'b0;
  logic [W-1:0] opnd [N];

  function automatic logic [W-1:0] pow5(input logic [W-1:0] n);
    int r;
    r = 1;
    for (int i = 0; i < 5; i++) r = (r * int'(n)) % 256;
    return W'(r);
  endfunction

  function automatic int pick(input logic [N-1:0] pend, input int p);
    for (int k = 0; k < N; k++) if (pend[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Unit stub living in the clk_en domain.
  logic         stub_act = 1'b0;
  int           stub_cnt = 0;
  logic [W-1:0] stub_n   = '0;
  always @(posedge clk) begin
    if (clk_en) en_edges <= en_edges + 1;
    if (clk_en) begin
      if (unit_n_vld) begin
        stub_act <= (lat != 0);
        stub_cnt <= lat - 1;
        stub_n   <= unit_n;
      end else if (stub_act) begin
        if (stub_cnt == 0) stub_act <= 1'b0;
        else stub_cnt <= stub_cnt - 1;
      end
    end
  end
  assign unit_res_vld = (stub_act && stub_cnt == 0) || stray;
  assign unit_res     = stub_act ? pow5(stub_n) : 8'h5A;

  initial begin
    int ph;
    ph = 0;
    clk_en = 1'b1;
    forever begin
      @(negedge clk);
      if (en_mode == 0) clk_en = 1'b1;
      else begin
        ph = (ph + 1) % 3;
        clk_en = (ph == 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic serve(input logic [N-1:0] set, input int L, input bit rnd);
    logic [N-1:0] pend;
    int w, t, e0, e1;
    bit ok;
    lat  = L;
    pend = set;
    for (int i = 0; i < N; i++)
      if (set[i]) begin
        req_n[i*W +: W] = opnd[i];
        req[i] = 1'b1;
      end
    while (pend != 0) begin
      if (rnd)
        for (int i = 0; i < N; i++)
          if (pend[i]) begin
            opnd[i] = W'($urandom);
            req_n[i*W +: W] = opnd[i];
          end
      w = pick(pend, ptr_m);
      t = 0;
      while (gnt == 0 && t < 400) begin @(negedge clk); t++; end
      check_val("gnt", 32'(gnt), 32'(1) << w);
      if (gnt == 0) return;
      check_val("unit_n", 32'(unit_n), 32'(opnd[w]));
      check_val("unit_n_vld", 32'(unit_n_vld), 1);
      check_val("busy_on", 32'(busy), 1);
      e0 = en_edges;
      req[w]  = 1'b0;
      pend[w] = 1'b0;
      @(negedge clk);
      check_val("gnt_pulse", 32'(gnt), 0);
      t = 0;
      while (rsp_vld == 0 && t < 400) begin @(negedge clk); t++; end
      check_val("rsp_vld", 32'(rsp_vld), 32'(1) << w);
      if (rsp_vld == 0) return;
      ok = (L >= 1 && L <= TO - 1);
      check_val("rsp_res", 32'(rsp_res), ok ? 32'(pow5(opnd[w])) : 0);
      check_val("rsp_err", 32'(rsp_err), ok ? 0 : 1);
      check_val("latency", 32'(en_edges - e0), ok ? 32'(L + 1) : 32'(TO));
      ptr_m = (w + 1) % N;
      e1 = en_edges;
      t = 0;
      while (rsp_vld != 0 && t < 400) begin @(negedge clk); t++; end
      check_val("rsp_len", 32'(en_edges - e1), 1);
      check_val("busy_idle", 32'(busy), 0);
    end
  endtask

  initial begin
    int t, bad, L;
    logic [N-1:0] set;
    rst = 1'b1; req = '0; req_n = '0;
    for (int i = 0; i < N; i++) opnd[i] = '0;
    repeat (3) @(negedge clk);
    check_val("rst_gnt", 32'(gnt), 0);
    check_val("rst_rsp_vld", 32'(rsp_vld), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_unit_n_vld", 32'(unit_n_vld), 0);
    check_val("rst_unit_n", 32'(unit_n), 0);
    check_val("rst_rsp_err", 32'(rsp_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single requester, exact latency.
    opnd[2] = 8'd3;
    serve(4'b0100, 5, 0);
    check_val("t1_res_243", 32'(pow5(8'd3)), 243);

    // Back to ptr 0, then all four held.
    serve(4'b1000, 2, 1);
    opnd[0] = 8'd1; opnd[1] = 8'd2; opnd[2] = 8'd3; opnd[3] = 8'd4;
    serve(4'b1111, 5, 0);

    // ptr = 1 with req[0] and req[3]: 3 first.
    serve(4'b0001, 3, 1);
    serve(4'b1001, 5, 1);

    // Timeout, then a stray result pulse.
    serve(4'b0010, 0, 1);
    repeat (2) @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_vld != 0 || busy || gnt != 0) bad++;
    end
    check_val("stray_ignored", 32'(bad), 0);

    // Result on the timeout cycle wins; one cycle later it is too late.
    serve(4'b0100, 15, 1);
    serve(4'b0100, 16, 1);
    serve(4'b0001, 1, 1);

    // clk_en one cycle in three.
    en_mode = 1;
    opnd[2] = 8'd3;
    serve(4'b0100, 5, 0);
    serve(4'b1000, 2, 1);
    opnd[0] = 8'd1; opnd[1] = 8'd2; opnd[2] = 8'd3; opnd[3] = 8'd4;
    serve(4'b1111, 5, 0);

    // Random mix.
    for (int it = 0; it < 8; it++) begin
      en_mode = int'($urandom_range(0, 1));
      set = N'($urandom_range(1, 15));
      case ($urandom_range(0, 5))
        0: L = 0;
        1: L = 1;
        2: L = 15;
        3: L = 16;
        default: L = int'($urandom_range(1, 20));
      endcase
      serve(set, L, 1);
    end

    // Reset while waiting on the unit.
    en_mode = 0;
    lat = 5;
    @(negedge clk);
    opnd[2] = 8'd7;
    req_n[2*W +: W] = opnd[2];
    req[2] = 1'b1;
    t = 0;
    while (gnt == 0 && t < 400) begin @(negedge clk); t++; end
    check_val("t6_gnt", 32'(gnt), 32'(1) << pick(4'b0100, ptr_m));
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("t6_gnt0", 32'(gnt), 0);
    check_val("t6_rsp_vld0", 32'(rsp_vld), 0);
    check_val("t6_rsp_res0", 32'(rsp_res), 0);
    check_val("t6_rsp_err0", 32'(rsp_err), 0);
    check_val("t6_busy0", 32'(busy), 0);
    check_val("t6_unit_n_vld0", 32'(unit_n_vld), 0);
    check_val("t6_unit_n0", 32'(unit_n), 0);
    rst = 1'b0;
    ptr_m = 0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_vld != 0 || busy) bad++;
    end
    check_val("t6_no_rsp", 32'(bad), 0);
    opnd[1] = W'($urandom);
    serve(4'b0010, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
